// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// FSM state encodings, default widths/sizes and a counter-width helper.
package regfile_wr_arbiter_pkg;

    localparam int WBA_ADDR_W       = 5;
    localparam int WBA_DATA_W       = 32;
    localparam int WBA_FIFO_DEPTH   = 4;
    localparam int WBA_STARVE_LIMIT = 8;

    typedef enum logic {
        WBA_NORMAL = 1'b0,
        WBA_FORCE  = 1'b1
    } wba_state_e;

    // Width of a counter that must hold 0 .. limit-1.
    function automatic int wba_cnt_w(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback / aux-result / regfile-write bundle for regfile_wr_arbiter.
// slave = the arbiter, master = the surrounding pipeline and regfile.
interface regfile_wr_arbiter_if
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int ADDR_W = WBA_ADDR_W,
    parameter int DATA_W = WBA_DATA_W
);
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              aux_valid;
    logic              aux_ready;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_data;
    logic              wb_stall;
    logic              wr_enable;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  aux_valid, aux_addr, aux_data,
        output aux_ready, wb_stall, wr_enable, wr_addr, wr_data, busy
    );

    modport master (
        output wb_valid, wb_addr, wb_data,
        output aux_valid, aux_addr, aux_data,
        input  aux_ready, wb_stall, wr_enable, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/regfile_wr_arbiter_fifo.sv
// Aux result queue (wb_arb_fifo): synchronous FIFO whose entries carry a
// valid bit that can be cleared by address match (kill_en/kill_addr) so a
// newer writeback to the same register invalidates stale queued results.
// Caller guarantees push only when !full and pop only when !empty.
module regfile_wr_arbiter_fifo
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int ADDR_W = WBA_ADDR_W,
    parameter int DATA_W = WBA_DATA_W,
    parameter int DEPTH  = WBA_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_kill,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [ADDR_W-1:0] kill_addr,
    output logic              full,
    output logic              empty,
    output logic              head_vld,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;

    // Pointers, occupancy and per-entry valid bits (kills land before the new entry is written).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            vld_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && (addr_q[i] == kill_addr)) begin
                    vld_q[i] <= 1'b0;
                end
            end
            if (push) begin
                vld_q[wr_ptr] <= !push_kill;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry payload storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign head_vld  = vld_q[rd_ptr];
    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter. Writeback owns the port; queued aux
// results drain in idle slots. After STARVE_LIMIT consecutive blocked
// cycles a one-cycle FORCE slot stalls writeback so the head drains.
// Writes to register 0 are consumed without asserting wr_enable.
// Optional: define WB_ARB_BYPASS_EN to let an aux result skip the empty
// queue and take an idle port in the same cycle.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int REG_ADDR_W   = WBA_ADDR_W,
    parameter int REG_DATA_W   = WBA_DATA_W,
    parameter int FIFO_DEPTH   = WBA_FIFO_DEPTH,
    parameter int STARVE_LIMIT = WBA_STARVE_LIMIT
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wr_arbiter_if.slave bus
);
    localparam int               CNT_W    = wba_cnt_w(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    wba_state_e          state;
    logic [CNT_W-1:0]    starve_cnt;
    logic                stall_q;
    logic                wr_enable_q;
    logic [REG_ADDR_W-1:0] wr_addr_q;
    logic [REG_DATA_W-1:0] wr_data_q;

    logic                f_empty;
    logic                f_full;
    logic                head_vld;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [REG_DATA_W-1:0] head_data;

    logic                in_force;
    logic                wb_grant;
    logic                head_live;
    logic                head_killed;
    logic                head_grant;
    logic                head_drop;
    logic                head_blocked;
    logic                byp_grant;
    logic                fifo_push;
    logic                fifo_pop;
    logic                push_kill;
    logic                grant_any;
    logic [REG_ADDR_W-1:0] grant_addr;
    logic [REG_DATA_W-1:0] grant_data;

    // Port arbitration: who owns the write port this cycle and what the queue does.
    always_comb begin
        in_force     = (state == WBA_FORCE);
        wb_grant     = !in_force && bus.wb_valid;
        head_live    = !f_empty && head_vld;
        head_killed  = wb_grant && (head_addr == bus.wb_addr);
        head_grant   = head_live && (in_force || !bus.wb_valid);
        // A killed head leaves the queue without needing the port.
        head_drop    = !f_empty && !head_vld;
        head_blocked = head_live && wb_grant && !head_killed;
`ifdef WB_ARB_BYPASS_EN
        byp_grant    = !in_force && f_empty && !bus.wb_valid && bus.aux_valid;
`else
        byp_grant    = 1'b0;
`endif
        fifo_push    = bus.aux_valid && !f_full && !byp_grant;
        fifo_pop     = head_grant || head_drop;
        // An aux result arriving alongside a writeback to the same register is older.
        push_kill    = wb_grant && (bus.aux_addr == bus.wb_addr);
        grant_any    = wb_grant || head_grant || byp_grant;
        grant_addr   = bus.wb_addr;
        grant_data   = bus.wb_data;
        if (head_grant) begin
            grant_addr = head_addr;
            grant_data = head_data;
        end else if (byp_grant) begin
            grant_addr = bus.aux_addr;
            grant_data = bus.aux_data;
        end
    end

    regfile_wr_arbiter_fifo #(
        .ADDR_W (REG_ADDR_W),
        .DATA_W (REG_DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_addr (bus.aux_addr),
        .push_data (bus.aux_data),
        .push_kill (push_kill),
        .pop       (fifo_pop),
        .kill_en   (wb_grant),
        .kill_addr (bus.wb_addr),
        .full      (f_full),
        .empty     (f_empty),
        .head_vld  (head_vld),
        .head_addr (head_addr),
        .head_data (head_data)
    );

    // Starvation FSM: count blocked cycles, take one FORCE slot with a registered stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WBA_NORMAL;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            case (state)
                WBA_NORMAL: begin
                    if (head_blocked) begin
                        if (starve_cnt == CNT_LAST) begin
                            state      <= WBA_FORCE;
                            starve_cnt <= '0;
                            stall_q    <= 1'b1;
                        end else begin
                            starve_cnt <= starve_cnt + 1'b1;
                            stall_q    <= 1'b0;
                        end
                    end else begin
                        starve_cnt <= '0;
                        stall_q    <= 1'b0;
                    end
                end
                WBA_FORCE: begin
                    state      <= WBA_NORMAL;
                    starve_cnt <= '0;
                    stall_q    <= 1'b0;
                end
                default: begin
                    state      <= WBA_NORMAL;
                    starve_cnt <= '0;
                    stall_q    <= 1'b0;
                end
            endcase
        end
    end

    // Registered regfile write port; register 0 is granted but never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_enable_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_enable_q <= grant_any && (grant_addr != '0);
            if (grant_any) begin
                wr_addr_q <= grant_addr;
                wr_data_q <= grant_data;
            end
        end
    end

    assign bus.aux_ready = !f_full;
    assign bus.wb_stall  = stall_q;
    assign bus.wr_enable = wr_enable_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = !f_empty || (state == WBA_FORCE);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: vector table, directed multi-cycle
// sequences, then randomized traffic against a queue-based reference model.
module tb_regfile_wr_arbiter;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
`ifdef WB_ARB_BYPASS_EN
    localparam bit BYP    = 1'b1;
    localparam int T2_LAT = 1;
`else
    localparam bit BYP    = 1'b0;
    localparam int T2_LAT = 2;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_wr_arbiter #(
        .REG_ADDR_W   (AW),
        .REG_DATA_W   (DW),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        bus.wb_valid  = wv;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        bus.aux_valid = av;
        bus.aux_addr  = aa;
        bus.aux_data  = ad;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        bit            en;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        bit            busy;
    } vec_t;

    function automatic vec_t mk(bit wv, int wa, int wd, bit av, int aa, int ad,
                                bit en, int ea, int ed, bit busy);
        vec_t v;
        v.wv = wv; v.wa = AW'(wa); v.wd = DW'(wd);
        v.av = av; v.aa = AW'(aa); v.ad = DW'(ad);
        v.en = en; v.ea = AW'(ea); v.ed = DW'(ed); v.busy = busy;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            live;
    } ent_t;

    ent_t          m_q[$];
    bit            m_force;
    int            m_cnt;
    bit            m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            m_stall;

    task automatic model_reset();
        m_q.delete();
        m_force = 0; m_cnt = 0; m_en = 0; m_addr = '0; m_data = '0; m_stall = 0;
    endtask

    // One clock of the arbitration rules, applied to the queue of pending aux results.
    task automatic model_step(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        bit            rdy = (m_q.size() < DEPTH);
        bit            was_force = m_force;
        bit            g = 0;
        bit            byp = 0;
        bit            blocked = 0;
        logic [AW-1:0] ga = '0;
        logic [DW-1:0] gd = '0;
        ent_t          h;
        m_stall = 0;
        if (was_force) begin
            if (m_q.size() > 0) begin
                h = m_q.pop_front();
                if (h.live) begin g = 1; ga = h.addr; gd = h.data; end
            end
            m_force = 0;
        end else if (wv) begin
            g = 1; ga = wa; gd = wd;
            if (m_q.size() > 0) begin
                if (!m_q[0].live) void'(m_q.pop_front());
                else if (m_q[0].addr != wa) blocked = 1;
            end
            foreach (m_q[i]) if (m_q[i].addr == wa) m_q[i].live = 0;
        end else if (m_q.size() > 0) begin
            h = m_q.pop_front();
            if (h.live) begin g = 1; ga = h.addr; gd = h.data; end
        end else if (BYP && av) begin
            byp = 1; g = 1; ga = aa; gd = ad;
        end
        if (blocked) begin
            if (m_cnt == LIMIT - 1) begin
                m_force = 1; m_stall = 1; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
        end
        if (av && rdy && !byp) begin
            ent_t e;
            e.addr = aa; e.data = ad;
            e.live = !(wv && !was_force && (aa == wa));
            m_q.push_back(e);
        end
        m_en = g && (ga != 0);
        if (g) begin m_addr = ga; m_data = gd; end
    endtask

    initial begin
        vec_t tbl[12];
        int   k;
        int   seen;
        bit   av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        bit   wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        int   wb_pct;

        drive(0, '0, '0, 0, '0, '0);
        reset = 1'b1;
        tick();
        tick();
        chk("rst_wr_enable", bus.wr_enable, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_wb_stall", bus.wb_stall, 0);
        chk("rst_aux_ready", bus.aux_ready, 1);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
        tick();

        // Table: continuous wb, wb kill of queued aux, x0 writes, kill of a same-cycle push.
        tbl[0]  = mk(1, 3, 'hA,  0, 0, 0,     1, 3, 'hA,  0);
        tbl[1]  = mk(1, 3, 'hA,  0, 0, 0,     1, 3, 'hA,  0);
        tbl[2]  = mk(1, 3, 'hA,  0, 0, 0,     1, 3, 'hA,  0);
        tbl[3]  = mk(0, 0, 0,    0, 0, 0,     0, 0, 0,    0);
        tbl[4]  = mk(1, 2, 'h20, 1, 9, 'h1,   1, 2, 'h20, 1);
        tbl[5]  = mk(1, 9, 'h2,  0, 0, 0,     1, 9, 'h2,  1);
        tbl[6]  = mk(0, 0, 0,    0, 0, 0,     0, 0, 0,    0);
        tbl[7]  = mk(0, 0, 0,    0, 0, 0,     0, 0, 0,    0);
        tbl[8]  = mk(1, 0, 'h5,  0, 0, 0,     0, 0, 0,    0);
        tbl[9]  = mk(1, 4, 'h44, 1, 4, 'h40,  1, 4, 'h44, 1);
        tbl[10] = mk(0, 0, 0,    0, 0, 0,     0, 0, 0,    0);
        tbl[11] = mk(0, 0, 0,    0, 0, 0,     0, 0, 0,    0);
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].av, tbl[i].aa, tbl[i].ad);
            tick();
            chk($sformatf("tbl%0d_en", i), bus.wr_enable, tbl[i].en);
            if (tbl[i].en) begin
                chk($sformatf("tbl%0d_addr", i), bus.wr_addr, tbl[i].ea);
                chk($sformatf("tbl%0d_data", i), bus.wr_data, tbl[i].ed);
            end
            chk($sformatf("tbl%0d_stall", i), bus.wb_stall, 0);
            chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].busy);
        end
        drive(0, '0, '0, 0, '0, '0);
        tick();

        // Aux latency with idle writeback.
        drive(0, '0, '0, 1, 5, 'h55);
        k = -1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            drive(0, '0, '0, 0, '0, '0);
            if (bus.wr_enable) begin k = c; break; end
        end
        chk("t2_latency", k, T2_LAT);
        chk("t2_addr", bus.wr_addr, 5);
        chk("t2_data", bus.wr_data, 'h55);
        tick();
        tick();

        // Starvation: aux (7,0x77) behind continuous writeback to reg 1.
        drive(1, 1, 'h11, 1, 7, 'h77);
        tick();
        drive(1, 1, 'h11, 0, '0, '0);
        k = -1;
        for (int c = 2; c <= 20; c++) begin
            tick();
            if (bus.wb_stall) begin k = c; break; end
        end
        chk("t3_stall_edge", k, 9);
        chk("t3_busy_force", bus.busy, 1);
        chk("t3_pre_addr", bus.wr_addr, 1);
        tick();
        chk("t3_stall_one", bus.wb_stall, 0);
        chk("t3_force_en", bus.wr_enable, 1);
        chk("t3_force_addr", bus.wr_addr, 7);
        chk("t3_force_data", bus.wr_data, 'h77);
        tick();
        chk("t3_resume_addr", bus.wr_addr, 1);
        chk("t3_resume_data", bus.wr_data, 'h11);
        chk("t3_resume_busy", bus.busy, 0);
        drive(0, '0, '0, 0, '0, '0);
        tick();

        // Fill the queue behind busy writeback; fifth result waits for the first pop.
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_ready_pre%0d", i), bus.aux_ready, 1);
            drive(1, 1, 'h11, 1, AW'(10 + i), DW'('h100 + i));
            tick();
        end
        drive(1, 1, 'h11, 1, 14, 'h104);
        chk("t5_full", bus.aux_ready, 0);
        tick();
        chk("t5_hold_a", bus.aux_ready, 0);
        tick();
        chk("t5_hold_b", bus.aux_ready, 0);
        drive(0, '0, '0, 1, 14, 'h104);
        for (int j = 0; j < 5; j++) begin
            tick();
            if (j == 0) chk("t5_ready_after_pop", bus.aux_ready, 1);
            if (j == 1) drive(0, '0, '0, 0, '0, '0);
            chk($sformatf("t5_en%0d", j), bus.wr_enable, 1);
            chk($sformatf("t5_addr%0d", j), bus.wr_addr, 10 + j);
            chk($sformatf("t5_data%0d", j), bus.wr_data, 'h100 + j);
        end
        tick();
        chk("t5_drained", bus.busy, 0);

        // Reset with three queued results and a FORCE slot pending.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 'h11, 1, AW'(20 + i), DW'('h200 + i));
            tick();
        end
        drive(1, 1, 'h11, 0, '0, '0);
        k = -1;
        for (int c = 0; c < 20; c++) begin
            if (bus.wb_stall) begin k = c; break; end
            tick();
        end
        chk("t6_force_seen", (k >= 0), 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_en", bus.wr_enable, 0);
        chk("t6_rst_addr", bus.wr_addr, 0);
        chk("t6_rst_data", bus.wr_data, 0);
        chk("t6_rst_stall", bus.wb_stall, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_ready", bus.aux_ready, 1);
        drive(0, '0, '0, 0, '0, '0);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.wr_enable || bus.busy || bus.wb_stall) seen++;
        end
        chk("t6_no_stale", seen, 0);

        // Randomized traffic against the reference model.
        model_reset();
        av = 0; aa = '0; ad = '0;
        wb_pct = 50;
        for (int n = 0; n < 2500; n++) begin
            if ((n % 64) == 0) wb_pct = ($urandom_range(0, 1) != 0) ? 90 : 45;
            if (!(av && (m_q.size() >= DEPTH))) begin
                av = ($urandom_range(0, 99) < 40);
                aa = AW'($urandom_range(0, 7));
                ad = $urandom;
            end
            wv = ($urandom_range(0, 99) < wb_pct);
            wa = AW'($urandom_range(0, 7));
            wd = $urandom;
            drive(wv, wa, wd, av, aa, ad);
            model_step(wv, wa, wd, av, aa, ad);
            tick();
            chk("rnd_en", bus.wr_enable, m_en);
            if (m_en) begin
                chk("rnd_addr", bus.wr_addr, m_addr);
                chk("rnd_data", bus.wr_data, m_data);
            end
            chk("rnd_stall", bus.wb_stall, m_stall);
            chk("rnd_ready", bus.aux_ready, (m_q.size() < DEPTH));
            chk("rnd_busy", bus.busy, ((m_q.size() > 0) || m_force));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
